// File: rtl/bus_slave_pkg.sv
// Shared definitions for the bus slave port.
//   state_e       : FSM state encoding (also exported on the debug port)
//   START_PATTERN : the three-bit frame start marker
//   frame_len()   : total control frame length in bits
//   ctrl_len()    : frame bits that follow the start marker
package bus_slave_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_CTRL  = 3'd2,
    S_SKIP  = 3'd3,
    S_WRITE = 3'd4,
    S_READ  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [2:0] START_PATTERN = 3'b111;
  localparam int         START_LEN     = 3;

  // Frame: start marker, id, R/W, B, start address.
  function automatic int frame_len(input int id_w, input int addr_w);
    return START_LEN + id_w + 2 + addr_w;
  endfunction

  function automatic int ctrl_len(input int id_w, input int addr_w);
    return frame_len(id_w, addr_w) - START_LEN;
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Parametrised shift register used both as SIPO (serial in, parallel out)
// and PISO (parallel load, MSB shifted out first), with a bit counter.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clr_i          : clear the bit counter only (contents are kept)
//   load_i         : parallel load of load_data_i, counter restarts at 0
//   shift_i        : shift left by one, ser_i enters at the LSB
//   ser_i          : serial input bit
//   load_data_i    : parallel load value
//   par_o          : register contents (MSB is the serial output bit)
//   last_o         : counter sits on the final bit of a W-bit word
module bus_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         ser_i,
  input  logic [W-1:0] load_data_i,
  output logic [W-1:0] par_o,
  output logic         last_o
);

  localparam int            CW     = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(W - 1);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      sr_d  = load_data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[W-2:0], ser_i};
      // Counter wraps at the word boundary so bursts restart cleanly.
      cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign par_o  = sr_q;
  assign last_o = (cnt_q == LAST_C);

endmodule

// File: rtl/bus_slave_port.sv
// Serial bus slave port with local word storage.
// A master sends a control frame on `control` (111, id, R/W, B, address),
// then streams write data on wD or receives read data on rD.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   control    : serial control frame, MSB first, idle low
//   wD         : serial write data, MSB first
//   valid      : master qualifier (write bit valid / read-continue request)
//   rD         : serial read data, MSB first
//   ready      : high on every cycle rD carries a valid bit
//   busy       : FSM is not idle
//   done       : one-cycle pulse at transaction end
//   err        : sticky error (bad address, or bad write parity)
//   dbg_state  : current FSM state, for observation only
// Build option: define BUS_SLAVE_PARITY_EN to append an even-parity bit
// to every data word in both directions.
//
// Handshake: during WRITE a wD bit is consumed only on cycles with
// valid=1. During READ every cycle with ready=1 carries one rD bit; the
// master requests the next burst word by holding valid=1 on the last bit
// cycle of the current word, otherwise the transaction ends.
module bus_slave_port
  import bus_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int SLAVE_ID_W = 2,
  parameter int SLAVE_ID   = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   control,
  input  logic   wD,
  input  logic   valid,
  output logic   rD,
  output logic   ready,
  output logic   busy,
  output logic   done,
  output logic   err,
  output state_e dbg_state
);

`ifdef BUS_SLAVE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_WIDTH + PAR_W;
  localparam int CTRL_W = ctrl_len(SLAVE_ID_W, ADDR_WIDTH);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [SLAVE_ID_W-1:0] MY_ID   = SLAVE_ID_W'(SLAVE_ID);

  state_e                  state_q, state_d;
  logic                    start_cnt_q, start_cnt_d;
  logic                    b_q, b_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_inc;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic                    wbound_q, wbound_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic                    mem_we;

  logic                    frm_clr, frm_shift, frm_last, frm_msb_unused;
  logic [CTRL_W-1:0]       frm_par, frame;
  logic                    dat_clr, dat_load, dat_shift, dat_ser, dat_last;
  logic [WORD_W-1:0]       dat_par, dat_ld, word_in;
  logic                    par_ok;

  logic [SLAVE_ID_W-1:0]   f_id;
  logic                    f_rw, f_b;
  logic [ADDR_WIDTH-1:0]   f_addr;

  bus_shift_reg #(.W(CTRL_W)) u_frame (
    .clk(clk), .rst(rst), .clr_i(frm_clr), .load_i(1'b0),
    .shift_i(frm_shift), .ser_i(control), .load_data_i('0),
    .par_o(frm_par), .last_o(frm_last)
  );

  bus_shift_reg #(.W(WORD_W)) u_data (
    .clk(clk), .rst(rst), .clr_i(dat_clr), .load_i(dat_load),
    .shift_i(dat_shift), .ser_i(dat_ser), .load_data_i(dat_ld),
    .par_o(dat_par), .last_o(dat_last)
  );

  // Complete frame / word including the bit arriving this cycle, so the
  // decision is taken on the same edge that samples the final bit.
  assign frame          = {frm_par[CTRL_W-2:0], control};
  assign frm_msb_unused = frm_par[CTRL_W-1];
  assign f_id           = frame[CTRL_W-1 -: SLAVE_ID_W];
  assign f_rw           = frame[ADDR_WIDTH+1];
  assign f_b            = frame[ADDR_WIDTH];
  assign f_addr         = frame[ADDR_WIDTH-1:0];
  assign word_in        = {dat_par[WORD_W-2:0], wD};
  assign addr_inc       = (addr_q == LAST_A) ? '0 : addr_q + ADDR_WIDTH'(1);

`ifdef BUS_SLAVE_PARITY_EN
  assign dat_ld = {mem_q[addr_q], ^mem_q[addr_q]};
  assign par_ok = ~^word_in;
`else
  assign dat_ld = mem_q[addr_q];
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    b_d         = b_q;
    addr_d      = addr_q;
    ready_d     = ready_q;
    err_d       = err_q;
    wbound_d    = wbound_q;
    frm_clr     = 1'b0;
    frm_shift   = 1'b0;
    dat_clr     = 1'b0;
    dat_load    = 1'b0;
    dat_shift   = 1'b0;
    dat_ser     = 1'b0;
    mem_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        frm_clr = 1'b1;
        dat_clr = 1'b1;
        if (control == START_PATTERN[2]) begin
          state_d     = S_START;
          start_cnt_d = 1'b0;
        end
      end
      S_START: begin
        if (control == START_PATTERN[start_cnt_q ? 0 : 1]) begin
          start_cnt_d = 1'b1;
          if (start_cnt_q) state_d = S_CTRL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CTRL: begin
        frm_shift = 1'b1;
        if (frm_last) begin
          if (f_id != MY_ID) begin
            state_d = S_SKIP;
          end else if ({1'b0, f_addr} >= DEPTH_C) begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end else begin
            b_d      = f_b;
            addr_d   = f_addr;
            wbound_d = 1'b0;
            ready_d  = 1'b0;
            state_d  = f_rw ? S_WRITE : S_READ;
          end
        end
      end
      S_SKIP: state_d = S_IDLE;
      S_WRITE: begin
        if (valid) begin
          dat_shift = 1'b1;
          dat_ser   = wD;
          wbound_d  = 1'b0;
          if (dat_last) begin
            if (par_ok) begin
              mem_we = 1'b1;
              addr_d = addr_inc;
              if (b_q) wbound_d = 1'b1;
              else     state_d  = S_DONE;
            end else begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end else if (wbound_q) begin
          // Idle cycle right after a burst word boundary closes the burst.
          state_d = S_DONE;
        end
      end
      S_READ: begin
        if (!ready_q) begin
          dat_load = 1'b1;
          addr_d   = addr_inc;
          ready_d  = 1'b1;
        end else if (dat_last) begin
          if (b_q && valid) begin
            dat_load = 1'b1;
            addr_d   = addr_inc;
          end else begin
            ready_d = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          dat_shift = 1'b1;
        end
      end
      S_DONE: begin
        dat_clr = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_cnt_q <= 1'b0;
      b_q         <= 1'b0;
      addr_q      <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      wbound_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      b_q         <= b_d;
      addr_q      <= addr_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      wbound_q    <= wbound_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[addr_q] <= word_in[WORD_W-1 -: DATA_WIDTH];
  end

  assign rD        = ready_q & dat_par[WORD_W-1];
  assign ready     = ready_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed, table-driven bench for bus_slave_port
// (DATA_WIDTH=8, MEM_DEPTH=16, ADDR_WIDTH=4, SLAVE_ID=2'b10).
module tb_bus_slave_port;
  import bus_slave_pkg::*;

`ifdef BUS_SLAVE_PARITY_EN
  localparam int TW = 9;
`else
  localparam int TW = 8;
`endif
  localparam logic [1:0] MY_ID = 2'b10;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst, control, wD, valid;
  logic   rD, ready, busy, done, err;
  state_e dbg_state;

  always #5 clk = ~clk;

  bus_slave_port #(
    .DATA_WIDTH(8), .MEM_DEPTH(16), .ADDR_WIDTH(4),
    .SLAVE_ID_W(2), .SLAVE_ID(2)
  ) dut (
    .clk(clk), .rst(rst), .control(control), .wD(wD), .valid(valid),
    .rD(rD), .ready(ready), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] mk_word(input logic [7:0] d);
`ifdef BUS_SLAVE_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  task automatic send_frame(input logic [1:0] id, input logic rw, input logic b,
                            input logic [3:0] addr);
    logic [10:0] f;
    f = {3'b111, id, rw, b, addr};
    for (int i = 10; i >= 0; i--) begin
      control = f[i];
      tick();
    end
    control = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  id;
    logic        rw;
    logic        b;
    logic [3:0]  addr;
    int          nw;
    logic [23:0] d;   // word0 in [23:16]; write data or expected read data
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] id, input logic rw, input logic b,
                               input logic [3:0] addr, input int nw, input logic [23:0] d);
    vec_t v;
    v.id = id; v.rw = rw; v.b = b; v.addr = addr; v.nw = nw; v.d = d;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [TW-1:0] tw;
    logic [TW-1:0] got;
    logic [7:0]    e;
    logic          noise;
    int            rdy_cnt;
    send_frame(v.id, v.rw, v.b, v.addr);
    if (v.id != MY_ID) begin
      check("skip_busy", busy, 1);
      noise = 1'b0;
      tw = mk_word(v.d[23:16]);
      for (int i = TW - 1; i >= 0; i--) begin
        valid = 1'b1; wD = tw[i];
        tick();
        noise |= ready | done | err;
      end
      valid = 1'b0; wD = 1'b0;
      check("skip_quiet", noise, 0);
      check("skip_idle", busy, 0);
    end else if (v.rw) begin
      for (int w = 0; w < v.nw; w++) begin
        tw = mk_word(v.d[23 - 8*w -: 8]);
        for (int i = TW - 1; i >= 0; i--) begin
          valid = 1'b1; wD = tw[i];
          tick();
        end
      end
      valid = 1'b0; wD = 1'b0;
      if (v.b) tick();
      check("wr_done", done, 1);
      tick();
      check("wr_idle", {busy, done}, 0);
    end else begin
      for (int w = 0; w < v.nw; w++) exp_q.push_back(v.d[23 - 8*w -: 8]);
      check("rd_latency", ready, 0);
      tick();
      rdy_cnt = 0;
      for (int w = 0; w < v.nw; w++) begin
        got = '0;
        for (int i = TW - 1; i >= 0; i--) begin
          if (ready) rdy_cnt++;
          got[i] = rD;
          valid = (i == 0) && (w < v.nw - 1);
          tick();
        end
        e = exp_q.pop_front();
        check("rd_data", 32'(got), 32'(mk_word(e)));
      end
      valid = 1'b0;
      check("rd_ready_cycles", rdy_cnt, v.nw * TW);
      check("rd_done", {done, ready}, 2'b10);
      tick();
      check("rd_idle", {busy, done}, 0);
    end
    check("err_flag", err, exp_err);
  endtask

  // ---------------- test ----------------
  vec_t vecs[12];

  initial begin
    logic [TW-1:0] tw;
    rst = 1'b1; control = 1'b0; wD = 1'b0; valid = 1'b0;
    vecs[0]  = mkv(MY_ID, 1, 0, 4'h3, 1, 24'hA50000);
    vecs[1]  = mkv(MY_ID, 0, 0, 4'h3, 1, 24'hA50000);
    vecs[2]  = mkv(MY_ID, 1, 1, 4'hE, 3, 24'h112233);
    vecs[3]  = mkv(MY_ID, 0, 1, 4'hE, 3, 24'h112233);
    vecs[4]  = mkv(MY_ID, 0, 0, 4'hF, 1, 24'h220000);
    vecs[5]  = mkv(MY_ID, 0, 0, 4'h0, 1, 24'h330000);
    vecs[6]  = mkv(2'b01, 1, 0, 4'h3, 1, 24'h5A0000);
    vecs[7]  = mkv(MY_ID, 0, 0, 4'h3, 1, 24'hA50000);
    vecs[8]  = mkv(MY_ID, 1, 1, 4'h7, 2, 24'hC33C00);
    vecs[9]  = mkv(MY_ID, 0, 1, 4'h7, 2, 24'hC33C00);
    vecs[10] = mkv(MY_ID, 0, 0, 4'h8, 1, 24'h3C0000);
    vecs[11] = mkv(MY_ID, 0, 1, 4'hF, 2, 24'h223300);

    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_outputs", {rD, ready, busy, done, err}, 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // Aborted start marker 1,1,0.
    control = 1'b1; tick();
    control = 1'b1; tick();
    check("abort_busy", busy, 1);
    control = 1'b0; tick();
    check("abort_idle", {busy, err, done}, 0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Write with a mid-word stall; control toggling must be ignored.
    send_frame(MY_ID, 1, 0, 4'h5);
    tw = mk_word(8'h96);
    for (int i = TW - 1; i >= 0; i--) begin
      if (i == TW - 4) begin
        valid = 1'b0; control = 1'b1;
        tick(); tick();
        control = 1'b0;
      end
      valid = 1'b1; wD = tw[i];
      tick();
    end
    valid = 1'b0; wD = 1'b0;
    check("stall_done", done, 1);
    tick();
    check("stall_idle", busy, 0);
    run_vec(mkv(MY_ID, 0, 0, 4'h5, 1, 24'h960000));

    // Reset after 5 bits of a word: no partial write.
    send_frame(MY_ID, 1, 0, 4'h3);
    tw = mk_word(8'h0F);
    for (int i = TW - 1; i > TW - 6; i--) begin
      valid = 1'b1; wD = tw[i];
      tick();
    end
    valid = 1'b0; rst = 1'b1;
    tick();
    check("rst_mid_outputs", {rD, ready, busy, done, err}, 0);
    check("rst_mid_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    tick();
    run_vec(mkv(MY_ID, 0, 0, 4'h3, 1, 24'hA50000));

`ifdef BUS_SLAVE_PARITY_EN
    // Bad parity: word dropped, err set, memory unchanged.
    send_frame(MY_ID, 1, 0, 4'h3);
    tw = {8'h5A, ~(^8'h5A)};
    for (int i = TW - 1; i >= 0; i--) begin
      valid = 1'b1; wD = tw[i];
      tick();
    end
    valid = 1'b0;
    check("par_done_err", {done, err}, 2'b11);
    tick();
    exp_err = 1'b1;
    run_vec(mkv(MY_ID, 0, 0, 4'h3, 1, 24'hA50000));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_slave_port.md
BUS_SLAVE_PORT -- requirements
Module: bus_slave_port

Interface
REQ-001 Parameter DATA_WIDTH, default 8: serial data word width in bits.
REQ-002 Parameter MEM_DEPTH, default 4096: number of words in local storage.
REQ-003 Parameter ADDR_WIDTH, default $clog2(MEM_DEPTH): width of the address field in the control frame.
REQ-004 Parameter SLAVE_ID_W, default 2: width of the slave-id field.
REQ-005 Parameter SLAVE_ID, default 0: this port's id.
REQ-006 clk  in  1  single clock, all logic on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 control  in  1  serial control frame, MSB first, idle low.
REQ-009 wD  in  1  serial write data, MSB first.
REQ-010 valid  in  1  master qualifier: write bit valid, or read-continue request.
REQ-011 rD  out  1  serial read data, MSB first.
REQ-012 ready  out  1  high on every cycle rD carries a valid bit.
REQ-013 busy  out  1  high when the state is not IDLE.
REQ-014 done  out  1  one-cycle pulse at transaction end.
REQ-015 err  out  1  sticky error flag, cleared only by rst.

Function
REQ-016 Control frame, shall be sampled one bit per cycle:
- 3'b111 start,
- SLAVE_ID_W bits id,
- 1 bit R/W (1 = write),
- 1 bit B (burst),
- ADDR_WIDTH bits start address.
REQ-017 States shall be IDLE, START, CTRL, SKIP, WRITE, READ, DONE.
REQ-018 IDLE: control=1 shall go to START.
REQ-019 START: the port shall require two more 1 bits; any 0 shall return to IDLE with no error.
REQ-020 CTRL: the port shall shift the remaining 2+SLAVE_ID_W+ADDR_WIDTH bits.
REQ-021 If the id does not equal SLAVE_ID, the port shall enter SKIP and return to IDLE with no response, done, or error.
REQ-022 WRITE: on each cycle with valid=1, the port shall shift in wD.
REQ-023 WRITE: on the DATA_WIDTH-th bit, the port shall write mem[addr] in that same cycle and increment addr.
REQ-024 WRITE: cycles with valid=0 mid-word shall stall and not shift.
REQ-025 WRITE, B=0: after one word the port shall enter DONE.
REQ-026 WRITE, B=1: valid=0 on the cycle after a word boundary shall enter DONE; otherwise the burst continues.
REQ-027 READ: the word mem[addr] shall load in the cycle after the last CTRL bit.
REQ-028 READ: the first rD bit with ready=1 shall appear on the next cycle (latency 2 cycles from last control bit to first data bit).
REQ-029 READ: the port shall output one bit per cycle, with ready continuously high for the word.
REQ-030 READ, B=1: valid=1 on the last bit cycle of a word shall stream the next word without a gap.
REQ-031 READ, B=1: valid=0 on the last bit cycle shall enter DONE.
REQ-032 READ, B=0: the port shall output exactly one word.
REQ-033 Address arithmetic: addr shall increment modulo MEM_DEPTH, so MEM_DEPTH-1 wraps to 0, in both burst modes.
REQ-034 A start address >= MEM_DEPTH shall set err and enter SKIP.
REQ-035 DONE: the port shall pulse done for one cycle, then go to IDLE; ready=0.
REQ-036 control activity outside IDLE/START shall be ignored.

Reset
REQ-037 rst=1 shall force IDLE, addr=0, shift and bit counters to 0, rD=0, ready=0, busy=0, done=0, err=0.
REQ-038 Reset mid-transaction shall abort, with no memory write of a partial word.
REQ-039 Memory contents shall not be reset.

Configuration
REQ-040 Macro BUS_SLAVE_PARITY_EN defined: each data word carries a trailing even-parity bit on wD (write) and rD (read).
REQ-041 With BUS_SLAVE_PARITY_EN, a write parity mismatch shall drop the word (no write, no addr increment), set err, and enter DONE.
REQ-042 Macro BUS_SLAVE_PARITY_EN undefined: words shall be exactly DATA_WIDTH bits, with no parity logic.

Structure
REQ-043 Package bus_slave_pkg shall hold the state enum, the START_PATTERN=3'b111 constant, and a function computing frame length.
REQ-044 One sub-module, bus_shift_reg, shall provide a parametrised PISO/SIPO register with bit counter and word-boundary flag.
REQ-045 Target size shall be 120-400 lines of RTL.

Verification (DATA_WIDTH=8, MEM_DEPTH=16, ADDR_WIDTH=4, SLAVE_ID=2'b10)
REQ-046 Single write then single read:
- Stimulus: frame 111_10_1_0_0011 plus wD 8'hA5 with valid=1, then read frame 111_10_0_0_0011.
- Required response: rD 8'hA5 MSB first under ready, done pulsed twice, err=0.
REQ-047 Burst write wrap:
- Stimulus: write burst from addr 4'hE with 3 words 8'h11, 8'h22, 8'h33.
- Required response: mem[14]=11, mem[15]=22, mem[0]=33.
REQ-048 Burst read with gapless stream:
- Stimulus: read burst from addr 14, holding valid for 3 words.
- Required response: 24 consecutive ready cycles, data 11, 22, 33.
REQ-049 Id mismatch:
- Stimulus: frame id 2'b01 followed by wD traffic.
- Required response: busy until the frame ends, then IDLE; ready, done, and err stay 0, memory unchanged.
REQ-050 Aborted start pattern:
- Stimulus: control 1,1,0.
- Required response: return to IDLE, err=0.
REQ-051 Reset mid-write:
- Stimulus: rst asserted after 5 bits of a word.
- Required response: all outputs 0 on the next cycle; target word unchanged.
- With BUS_SLAVE_PARITY_EN: a bad parity on 8'hA5 sets err and leaves memory unchanged.
